// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH, so WIDTH=1 still gets a 1-bit counter.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand and result handshakes of the bit-serial adder.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
// ready never depends combinationally on valid, and the producer keeps data stable while valid waits.
interface serial_add_seq_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/ha_bit.sv
// Combinational half-adder cell; two of these form one full-adder bit slice.
module ha_bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder controller: accepts two operands, adds them LSB-first one bit per
// clock through a shared half-adder pair, then offers {cout, sum} until taken.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_seq_if.slave bus,
    output state_t         dbg_state
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] msb_bit;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             cout_r;
    logic             h1_s, h1_c, h2_s, h2_c;
    logic             c_next;

    ha_bit u_ha1 (.a(sa[0]), .b(sb[0]), .s(h1_s), .c(h1_c));
    ha_bit u_ha2 (.a(h1_s),  .b(c),     .s(h2_s), .c(h2_c));

    assign c_next = h1_c | h2_c;

    // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at sum[0].
    always_comb begin
        msb_bit            = '0;
        msb_bit[WIDTH-1]   = h2_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa    <= bus.op_a;
                        sb    <= bus.op_b;
                        c     <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= c_next;
                    res <= (res >> 1) | msb_bit;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cout_r <= c_next;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.sum       = res;
    assign bus.cout      = cout_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: WIDTH=8 and WIDTH=1 instances on one clock.
module tb_serial_add_seq;
    import serial_add_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dbg8;
    state_t dbg1;
    int     tests_run;
    int     tests_failed;

    serial_add_seq_if #(.WIDTH(8)) bus8 ();
    serial_add_seq_if #(.WIDTH(1)) bus1 ();

    serial_add_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_state(dbg8));
    serial_add_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver + inline checks for one WIDTH=8 addition with a single-cycle take
    task automatic add8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_s, input logic exp_c, input string name);
        int n;
        tests_run++;
        if (bus8.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, bus8.in_ready);
        end
        bus8.in_valid = 1'b1;
        bus8.op_a = a;
        bus8.op_b = b;
        step();
        bus8.in_valid = 1'b0;
        bus8.op_a = 8'($urandom_range(0, 255));
        bus8.op_b = 8'($urandom_range(0, 255));
        n = 0;
        while (bus8.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want 8", name, n);
        end
        tests_run++;
        if (bus8.sum !== exp_s || bus8.cout !== exp_c) begin
            tests_failed++;
            $display("FAIL %s result: got sum=%h cout=%b want sum=%h cout=%b",
                     name, bus8.sum, bus8.cout, exp_s, exp_c);
        end
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
        tests_run++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after take: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     name, bus8.out_valid, bus8.in_ready, bus8.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 ||
            bus8.sum !== 8'h00 || bus8.cout !== 1'b0 || dbg8 !== IDLE) begin
            tests_failed++;
            $display("FAIL reset8: got in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                     bus8.in_ready, bus8.out_valid, bus8.busy, bus8.sum, bus8.cout);
        end
        tests_run++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.sum !== 1'b0 || bus1.cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset1: got in_ready=%b out_valid=%b sum=%b cout=%b want 1 0 0 0",
                     bus1.in_ready, bus1.out_valid, bus1.sum, bus1.cout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        add8(8'h00, 8'h00, 8'h00, 1'b0, "zero");
        add8(8'hFF, 8'h01, 8'h00, 1'b1, "carry_wrap");
        add8(8'hA5, 8'h5A, 8'hFF, 1'b0, "alternating");
    endtask

    task automatic test_backpressure();
        int n;
        bus8.in_valid = 1'b1;
        bus8.op_a = 8'h3C;
        bus8.op_b = 8'h0F;
        step();
        // keep offering different operands; they must be ignored
        bus8.op_a = 8'hFF;
        bus8.op_b = 8'hFF;
        n = 0;
        while (bus8.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL bp latency: got %0d want 8", n);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'h4B || bus8.cout !== 1'b0 || bus8.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp hold %0d: got out_valid=%b sum=%h cout=%b in_ready=%b want 1 4b 0 0",
                         i, bus8.out_valid, bus8.sum, bus8.cout, bus8.in_ready);
            end
            step();
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
        tests_run++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp release: got in_ready=%b out_valid=%b want 1 0", bus8.in_ready, bus8.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        bus8.in_valid = 1'b1;
        bus8.op_a = 8'h12;
        bus8.op_b = 8'h34;
        bus8.out_ready = 1'b1;  // early out_ready must have no effect
        step();
        bus8.in_valid = 1'b0;
        step();
        step();
        step();  // cnt == 3 now
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 ||
            bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                     bus8.in_ready, bus8.out_valid, bus8.busy, bus8.sum, bus8.cout);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.out_valid === 1'b1) seen++;
            step();
        end
        bus8.out_ready = 1'b0;
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL mid_reset no_result: got %0d out_valid cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int hi;
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.op_a = 8'h80;
        bus8.op_b = 8'h80;
        step();
        bus8.in_valid = 1'b0;
        n = 0;
        while (bus8.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (n !== 8 || bus8.sum !== 8'h00 || bus8.cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b first: got lat=%0d sum=%h cout=%b want 8 00 1", n, bus8.sum, bus8.cout);
        end
        hi = 0;
        while (bus8.out_valid === 1'b1 && hi < 5) begin
            step();
            hi++;
        end
        tests_run++;
        if (hi !== 1 || bus8.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b pulse: got width=%0d in_ready=%b want 1 1", hi, bus8.in_ready);
        end
        bus8.in_valid = 1'b1;
        bus8.op_a = 8'h01;
        bus8.op_b = 8'h02;
        step();
        bus8.in_valid = 1'b0;
        tests_run++;
        if (bus8.busy !== 1'b1 || dbg8 !== RUN) begin
            tests_failed++;
            $display("FAIL b2b accept: got busy=%b state=%0d want 1 %0d", bus8.busy, dbg8, RUN);
        end
        n = 0;
        while (bus8.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (n !== 8 || bus8.sum !== 8'h03 || bus8.cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b second: got lat=%0d sum=%h cout=%b want 8 03 0", n, bus8.sum, bus8.cout);
        end
        step();
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_width1();
        logic [1:0] a_tab [2];
        logic [1:0] exp_tab [2];  // {cout, sum}
        int n;
        a_tab[0] = 2'b11; exp_tab[0] = 2'b10;  // 1+1
        a_tab[1] = 2'b10; exp_tab[1] = 2'b01;  // 1+0
        for (int k = 0; k < 2; k++) begin
            bus1.in_valid = 1'b1;
            bus1.op_a = a_tab[k][1];
            bus1.op_b = a_tab[k][0];
            step();
            bus1.in_valid = 1'b0;
            n = 0;
            while (bus1.out_valid !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            tests_run++;
            if (n !== 1 || {bus1.cout, bus1.sum} !== exp_tab[k]) begin
                tests_failed++;
                $display("FAIL width1 vec%0d: got lat=%0d cout=%b sum=%b want 1 %b %b",
                         k, n, bus1.cout, bus1.sum, exp_tab[k][1], exp_tab[k][0]);
            end
            bus1.out_ready = 1'b1;
            step();
            bus1.out_ready = 1'b0;
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.op_a = '0;
        bus8.op_b = '0;
        bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.op_a = '0;
        bus1.op_b = '0;
        bus1.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
